inst_buffer: RTL and testbench

- Decoupling FIFO between the fetch stage and decode.
- Fetch pushes one instruction per cycle (inst, PC, NPC); decode pops one per cycle.
- Absorbs icache/fetch bubbles and decode/dispatch stalls.
- A flush (branch mispredict / ROB redirect) squashes all buffered instructions in one cycle.

---
 rtl/inst_buffer.sv | 118 +++++++++++
 tb/tb_inst_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction FIFO with single-cycle flush.
// Optional same-cycle empty bypass is enabled by defining INST_BUF_BYPASS_EN.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module inst_buffer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ALMOST_FULL_TH = DEPTH - 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_npc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_npc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]     inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] npc_mem_q  [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic is_empty;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        is_empty = (count_q == '0);
        in_ready = (count_q != CW'(DEPTH));
`ifdef INST_BUF_BYPASS_EN
        bypass = is_empty & in_valid & ~flush;
`else
        bypass = 1'b0;
`endif
        // A bypassed beat that decode takes this cycle never enters storage.
        push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
        pop  = ~is_empty & out_ready & ~flush;
    end

    always_comb begin
        out_valid = ~is_empty | bypass;
        out_inst  = `NOP;
        out_pc    = '0;
        out_npc   = '0;
        if (bypass) begin
            out_inst = in_inst;
            out_pc   = in_pc;
            out_npc  = in_npc;
        end else if (!is_empty) begin
            out_inst = inst_mem_q[head_q];
            out_pc   = pc_mem_q[head_q];
            out_npc  = npc_mem_q[head_q];
        end
        empty       = is_empty;
        count       = count_q;
        almost_full = (count_q >= CW'(ALMOST_FULL_TH));
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents are never cleared; pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            inst_mem_q[tail_q] <= in_inst;
            pc_mem_q[tail_q]   <= in_pc;
            npc_mem_q[tail_q]  <= in_npc;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer (DEPTH=4): directed plan sequences plus random traffic.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module tb_inst_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef INST_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_npc;
    logic            in_ready;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_npc;
    logic            out_ready;
    logic [2:0]      count;
    logic            almost_full;
    logic            empty;

    inst_buffer #(
        .DEPTH(DEPTH),
        .XLEN(XLEN),
        .ALMOST_FULL_TH(DEPTH - 2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_inst(in_inst),
        .in_pc(in_pc),
        .in_npc(in_npc),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_inst(out_inst),
        .out_pc(out_pc),
        .out_npc(out_npc),
        .out_ready(out_ready),
        .count(count),
        .almost_full(almost_full),
        .empty(empty)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
    } beat_t;

    beat_t       exp_q[$];
    int          mcount;
    int          e_count;
    bit          e_valid;
    int unsigned vectors;
    int unsigned miscompares;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [XLEN-1:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    // One clock of stimulus; the FIFO model is a queue plus an occupancy count.
    task automatic cyc(input bit v, input logic [XLEN-1:0] pc, input bit ordy, input bit fl);
        bit byp, acc, stored, drained;
        in_valid  = v;
        in_pc     = pc;
        in_npc    = pc + 32'd4;
        in_inst   = inst_of(pc);
        out_ready = ordy;
        flush     = fl;
        byp     = BYP && mcount == 0 && v && !fl;
        acc     = v && mcount != DEPTH && !fl;
        stored  = acc && !(byp && ordy);
        drained = mcount != 0 && ordy && !fl;
        e_count = mcount;
        e_valid = (mcount != 0) || byp;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back('{inst: inst_of(pc), pc: pc, npc: pc + 32'd4});
        @(posedge clock);
        #1;
        if (fl) mcount = 0;
        else mcount = mcount + int'(stored) - int'(drained);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            beat_t b;
            check("out_valid", 64'(out_valid), 64'(e_valid));
            check("count", 64'(count), 64'(e_count));
            check("in_ready", 64'(in_ready), 64'(e_count != DEPTH));
            check("almost_full", 64'(almost_full), 64'(e_count >= DEPTH - 2));
            check("empty", 64'(empty), 64'(e_count == 0));
            if (!e_valid) begin
                check("idle_inst", 64'(out_inst), 64'(`NOP));
                check("idle_pc", 64'(out_pc), 64'd0);
                check("idle_npc", 64'(out_npc), 64'd0);
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL underflow: got pop with pc %0h required no pop", out_pc);
                end else begin
                    b = exp_q.pop_front();
                    check("out_inst", 64'(out_inst), 64'(b.inst));
                    check("out_pc", 64'(out_pc), 64'(b.pc));
                    check("out_npc", 64'(out_npc), 64'(b.npc));
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mcount      = 0;
        e_count     = 0;
        e_valid     = 1'b0;
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_inst     = '0;
        in_pc       = '0;
        in_npc      = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_inst", 64'(out_inst), 64'(`NOP));

        // Fill, then a held fifth beat.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_pc", 64'(out_pc), 64'h0);
        repeat (2) cyc(1'b1, 32'h10, 1'b0, 1'b0);

        // Drain two, refill across the wrap, drain all.
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous push/pop at count=2, then at full.
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h24, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(32'h28 + i * 4), 1'b1, 1'b0);
        check("pp_count", 64'(count), 64'd2);
        cyc(1'b1, 32'h3C, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 1'b1, 1'b0);
        check("pp_full_count", 64'(count), 64'd3);

        // Flush priority.
        cyc(1'b1, 32'h40, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        cyc(1'b1, 32'h80, 1'b0, 1'b0);
        check("post_flush_pc", 64'(out_pc), 64'h80);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Empty with a consuming decode: bypass or one-cycle latency.
        cyc(1'b1, 32'h100, 1'b1, 1'b0);
        check("byp_count", 64'(count), BYP ? 64'd0 : 64'd1);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3FFF), 2'b00},
                $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);

        repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("final_leftover", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
